// File: rtl/adc_word_packer.sv
// -----------------------------------------------------------------------------
// adc_word_packer
//
// Capture stage in front of the FX3 streaming write path. ADC samples are
// zero-extended into 16-bit lanes and packed two per 32-bit word (first
// sample in bits[15:0], second in bits[31:16]). The most recently completed
// word is kept in a one-word hold register so that, when a packet is closed
// early (capture disabled or idle timeout), that word can still be tagged as
// the packet end before it is written to the output FIFO. Words then wait in
// a first-word-fall-through FIFO for the consumer.
//
// Packets close after PKT_WORDS words, after TIMEOUT idle cycles with a word
// pending, or when enable falls.
//
// Handshake: the output is strict valid/ready. word_valid is high whenever
// the FIFO holds a word; word_data/word_last describe that head word in the
// same cycle. A word transfers on a rising clk edge where word_valid and
// word_ready are both high; word_valid never depends on word_ready. The input
// side has no back-pressure: adc_valid transfers one sample per high cycle.
//
// Ports
//   clk             in   1         system clock, rising edge
//   reset_from_fx3  in   1         asynchronous active-low reset
//   enable          in   1         capture enable
//   adc_data        in   SAMPLE_W  ADC sample
//   adc_valid       in   1         sample strobe, one sample per high cycle
//   word_data       out  32        packed word at FIFO head (0 when empty)
//   word_valid      out  1         FIFO non-empty
//   word_ready      in   1         consumer accepts head word
//   word_last       out  1         head word ends a packet
//   overflow        out  1         sticky: a word or sample was dropped
//   state_dbg       out  2         FSM state (0 idle, 1 run, 2 flush)
// -----------------------------------------------------------------------------
module adc_word_packer #(
    parameter int SAMPLE_W   = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_WORDS  = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                reset_from_fx3,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    output logic [31:0]         word_data,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                word_last,
    output logic                overflow,
    output logic [1:0]          state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PKT_WORDS);
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic           flush_step_q, flush_step_d;
    logic [15:0]    half_q, half_d;
    logic           half_valid_q, half_valid_d;
    logic [31:0]    hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic [CW-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
    logic           overflow_q, overflow_d;

    // FIFO storage and pointers (one extra bit to tell full from empty)
    logic [32:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        can_push;
    logic [32:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign can_push   = !fifo_full || pop;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign word_valid = !fifo_empty;
    assign word_data  = fifo_empty ? 32'h0 : head[31:0];
    assign word_last  = fifo_empty ? 1'b0  : head[32];
    assign overflow   = overflow_q;
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------
    // Sample lane: zero-extend to 16 bits
    // ------------------------------------------------------------------
    logic [15:0] lane;
    always_comb begin
        lane = '0;
        lane[SAMPLE_W-1:0] = adc_data;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic        push_en;
    logic [31:0] push_data;
    logic        push_last;
    logic        pkt_is_last;
    logic        timeout_hit;

    assign pkt_is_last = (pkt_cnt_q == CW'(PKT_WORDS - 1));
    assign timeout_hit = hold_valid_q && (idle_cnt_q == IW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        flush_step_d = flush_step_q;
        half_d       = half_q;
        half_valid_d = half_valid_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pkt_cnt_d    = pkt_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        overflow_d   = overflow_q;
        push_en      = 1'b0;
        push_data    = hold_q;
        push_last    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d      = S_RUN;
                    overflow_d   = 1'b0;
                    pkt_cnt_d    = '0;
                    idle_cnt_d   = '0;
                    half_valid_d = 1'b0;
                    hold_valid_d = 1'b0;
                end
            end

            S_RUN: begin
                if (adc_valid) begin
                    idle_cnt_d = '0;
                    if (!half_valid_q) begin
                        half_d       = lane;
                        half_valid_d = 1'b1;
                    end else begin
                        half_valid_d = 1'b0;
                        // Completed word: the previous word leaves hold for
                        // the FIFO, the new one takes its place.
                        if (hold_valid_q) begin
                            if (can_push) begin
                                push_en   = 1'b1;
                                push_last = pkt_is_last;
                                pkt_cnt_d = pkt_is_last ? '0 : pkt_cnt_q + 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        hold_d       = {lane, half_q};
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid_q && !timeout_hit) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end

                if (!enable || (!adc_valid && timeout_hit)) begin
                    state_d      = S_FLUSH;
                    flush_step_d = 1'b0;
                end
            end

            S_FLUSH: begin
                if (adc_valid) begin
                    overflow_d = 1'b1;
                end

                if (!flush_step_q) begin
                    // Step 0: turn a pending lower half into a word.
                    if (half_valid_q) begin
                        if (!hold_valid_q) begin
                            hold_d       = {16'h0, half_q};
                            hold_valid_d = 1'b1;
                            half_valid_d = 1'b0;
                            flush_step_d = 1'b1;
                        end else if (can_push) begin
                            push_en      = 1'b1;
                            push_last    = pkt_is_last;
                            pkt_cnt_d    = pkt_is_last ? '0 : pkt_cnt_q + 1'b1;
                            hold_d       = {16'h0, half_q};
                            hold_valid_d = 1'b1;
                            half_valid_d = 1'b0;
                            flush_step_d = 1'b1;
                        end
                        // else: FIFO full, wait here; flush pushes never drop.
                    end else if (hold_valid_q) begin
                        flush_step_d = 1'b1;
                    end else begin
                        state_d    = enable ? S_RUN : S_IDLE;
                        idle_cnt_d = '0;
                    end
                end else begin
                    // Step 1: close the packet with the held word.
                    if (hold_valid_q) begin
                        if (can_push) begin
                            push_en      = 1'b1;
                            push_last    = 1'b1;
                            hold_valid_d = 1'b0;
                            pkt_cnt_d    = '0;
                            state_d      = enable ? S_RUN : S_IDLE;
                            idle_cnt_d   = '0;
                        end
                    end else begin
                        state_d    = enable ? S_RUN : S_IDLE;
                        idle_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_from_fx3) begin
        if (!reset_from_fx3) begin
            state_q      <= S_IDLE;
            flush_step_q <= 1'b0;
            half_q       <= '0;
            half_valid_q <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pkt_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_step_q <= flush_step_d;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pkt_cnt_q    <= pkt_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_from_fx3) begin
        if (!reset_from_fx3) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers make stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_last, push_data};
        end
    end

endmodule
